// File: rtl/vrf_read_pkg.sv
// Shared types for the VRF read-port arbiter: request payload fields and their widths.
// No logic; used by the arbiter top and the testbench.
// No flow control here; the arbiter applies valid/ready.
package vrf_read_pkg;

  localparam int VS_W      = 5;
  localparam int SRC_W     = 2;
  localparam int OFF_W     = 7;
  localparam int IDX_INS_W = 3;
  localparam int REQ_W     = VS_W + SRC_W + OFF_W + IDX_INS_W;

  // One VRF read request as carried from a requester to the read port (17 bits).
  typedef struct packed {
    logic [VS_W-1:0]      vs;
    logic [SRC_W-1:0]     readSource;
    logic [OFF_W-1:0]     offset;
    logic [IDX_INS_W-1:0] instructionIndex;
  } vrf_read_req_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating-priority picker: first asserted req at or after ptr, wrapping modulo N.
// Purely combinational (0 cycles).
// No backpressure; the caller qualifies the grant with its own accept condition.
module rr_priority_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  int             pos;

  // Duplicate the request vector and keep only the N-bit window starting at ptr,
  // so a plain lowest-bit-first encode yields the round-robin winner.
  always_comb begin
    dbl = {req, req};
    for (int j = 0; j < 2*N; j++) begin
      masked[j] = dbl[j] && (j >= int'(ptr)) && (j < int'(ptr) + N);
    end
  end

  // Lowest set bit of the window, folded back into the 0..N-1 range.
  always_comb begin
    pos = 0;
    any = 1'b0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (masked[j]) begin
        pos = j;
        any = 1'b1;
      end
    end
    grant_idx = (pos >= N) ? IDX_W'(pos - N) : IDX_W'(pos);
    grant     = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = any && (grant_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/vrf_read_arbiter_rr.sv
// Round-robin arbiter sharing one VRF read port among NUM_REQ requesters, registered output.
// Latency 1 cycle from input handshake to io_out_valid; one grant per cycle at full rate.
// Output stall (valid && !ready) holds the payload and drops every io_in_ready.
module vrf_read_arbiter_rr
  import vrf_read_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           io_in_valid,
  output logic [NUM_REQ-1:0]           io_in_ready,
  input  logic [NUM_REQ*VS_W-1:0]      io_in_bits_vs,
  input  logic [NUM_REQ*SRC_W-1:0]     io_in_bits_readSource,
  input  logic [NUM_REQ*OFF_W-1:0]     io_in_bits_offset,
  input  logic [NUM_REQ*IDX_INS_W-1:0] io_in_bits_instructionIndex,
  input  logic                         io_out_ready,
  output logic                         io_out_valid,
  output logic [VS_W-1:0]              io_out_bits_vs,
  output logic [SRC_W-1:0]             io_out_bits_readSource,
  output logic [OFF_W-1:0]             io_out_bits_offset,
  output logic [IDX_INS_W-1:0]         io_out_bits_instructionIndex,
  output logic [IDX_W-1:0]             io_out_grantIndex
);

  vrf_read_req_t        in_req [NUM_REQ];
  vrf_read_req_t        sel_req;
  vrf_read_req_t        out_q;
  logic                 out_vld_q;
  logic [IDX_W-1:0]     out_idx_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [NUM_REQ-1:0]   win_gnt;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_any;
  logic                 can_accept;
  logic                 take;

  rr_priority_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req       (io_in_valid),
    .ptr       (ptr_q),
    .grant     (win_gnt),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  // Unpack the flat per-requester buses and mux out the winner's payload (one-hot select,
  // so the payload never feeds back into the ready path).
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      in_req[i].vs               = io_in_bits_vs[VS_W*i +: VS_W];
      in_req[i].readSource       = io_in_bits_readSource[SRC_W*i +: SRC_W];
      in_req[i].offset           = io_in_bits_offset[OFF_W*i +: OFF_W];
      in_req[i].instructionIndex = io_in_bits_instructionIndex[IDX_INS_W*i +: IDX_INS_W];
      if (win_gnt[i]) sel_req = in_req[i];
    end
  end

  assign can_accept  = !out_vld_q || io_out_ready;
  assign take        = !reset && can_accept && win_any;
  assign io_in_ready = (!reset && can_accept) ? win_gnt : '0;

  // Output stage: load on a new grant (even while the old one fires), clear valid on a bare fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
      out_idx_q <= '0;
    end else if (take) begin
      out_vld_q <= 1'b1;
      out_q     <= sel_req;
      out_idx_q <= win_idx;
    end else if (io_out_ready) begin
      out_vld_q <= 1'b0;
    end
  end

  // Priority pointer advances past the winner only on an input handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (take) begin
      ptr_q <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  assign io_out_valid                 = out_vld_q;
  assign io_out_bits_vs               = out_q.vs;
  assign io_out_bits_readSource       = out_q.readSource;
  assign io_out_bits_offset           = out_q.offset;
  assign io_out_bits_instructionIndex = out_q.instructionIndex;
  assign io_out_grantIndex            = out_idx_q;

endmodule

// File: tb/tb_vrf_read_arbiter_rr.sv
// Bench for vrf_read_arbiter_rr: a 4-way and a 3-way instance against a queue-free
// behavioural model (rotating scan with modulo arithmetic), plus directed literal checks.
module tb_vrf_read_arbiter_rr;
  import vrf_read_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Stimulus per instance: k=0 is the 4-way DUT, k=1 the 3-way DUT (entry 3 unused).
  logic [3:0]    vld  [2];
  logic          ordy [2];
  vrf_read_req_t pay  [2][4];
  int            nreq [2] = '{4, 3};

  logic [19:0] vs0;  logic [7:0] src0;  logic [27:0] off0;  logic [11:0] ins0;
  logic [14:0] vs1;  logic [5:0] src1;  logic [20:0] off1;  logic [8:0]  ins1;
  logic [3:0]  rdy0; logic [2:0] rdy1;
  logic        ov0, ov1;
  logic [4:0]  ovs0, ovs1;
  logic [1:0]  osrc0, osrc1;
  logic [6:0]  ooff0, ooff1;
  logic [2:0]  oins0, oins1;
  logic [1:0]  oidx0, oidx1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      vs0[5*i +: 5]  = pay[0][i].vs;
      src0[2*i +: 2] = pay[0][i].readSource;
      off0[7*i +: 7] = pay[0][i].offset;
      ins0[3*i +: 3] = pay[0][i].instructionIndex;
    end
    for (int i = 0; i < 3; i++) begin
      vs1[5*i +: 5]  = pay[1][i].vs;
      src1[2*i +: 2] = pay[1][i].readSource;
      off1[7*i +: 7] = pay[1][i].offset;
      ins1[3*i +: 3] = pay[1][i].instructionIndex;
    end
  end

  vrf_read_arbiter_rr #(.NUM_REQ(4)) dut4 (
    .clock(clock), .reset(reset),
    .io_in_valid(vld[0]), .io_in_ready(rdy0),
    .io_in_bits_vs(vs0), .io_in_bits_readSource(src0),
    .io_in_bits_offset(off0), .io_in_bits_instructionIndex(ins0),
    .io_out_ready(ordy[0]), .io_out_valid(ov0),
    .io_out_bits_vs(ovs0), .io_out_bits_readSource(osrc0),
    .io_out_bits_offset(ooff0), .io_out_bits_instructionIndex(oins0),
    .io_out_grantIndex(oidx0)
  );

  vrf_read_arbiter_rr #(.NUM_REQ(3)) dut3 (
    .clock(clock), .reset(reset),
    .io_in_valid(vld[1][2:0]), .io_in_ready(rdy1),
    .io_in_bits_vs(vs1), .io_in_bits_readSource(src1),
    .io_in_bits_offset(off1), .io_in_bits_instructionIndex(ins1),
    .io_out_ready(ordy[1]), .io_out_valid(ov1),
    .io_out_bits_vs(ovs1), .io_out_bits_readSource(osrc1),
    .io_out_bits_offset(ooff1), .io_out_bits_instructionIndex(oins1),
    .io_out_grantIndex(oidx1)
  );

  // DUT outputs gathered per instance.
  logic          d_ov   [2];
  vrf_read_req_t d_bits [2];
  int            d_idx  [2];
  int            d_rdy  [2];
  always_comb begin
    d_ov[0]   = ov0;
    d_ov[1]   = ov1;
    d_bits[0] = '{vs: ovs0, readSource: osrc0, offset: ooff0, instructionIndex: oins0};
    d_bits[1] = '{vs: ovs1, readSource: osrc1, offset: ooff1, instructionIndex: oins1};
    d_idx[0]  = int'(oidx0);
    d_idx[1]  = int'(oidx1);
    d_rdy[0]  = int'(rdy0);
    d_rdy[1]  = int'(rdy1);
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_ptr  [2] = '{0, 0};
  bit            m_ov   [2] = '{0, 0};
  vrf_read_req_t m_bits [2] = '{'0, '0};
  int            m_idx  [2] = '{0, 0};

  // First valid requester scanning from the pointer, wrapping modulo the requester count.
  function automatic int winner(input int k);
    for (int off = 0; off < nreq[k]; off++) begin
      int i;
      i = (m_ptr[k] + off) % nreq[k];
      if (vld[k][i]) return i;
    end
    return -1;
  endfunction

  function automatic int exp_ready(input int k);
    int w;
    w = winner(k);
    if (reset || !(!m_ov[k] || ordy[k]) || w < 0) return 0;
    return 1 << w;
  endfunction

  // Advance the model on each rising edge from the inputs present at that edge.
  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      int w;
      w = winner(k);
      if (reset) begin
        m_ov[k] = 0; m_bits[k] = '0; m_idx[k] = 0; m_ptr[k] = 0;
      end else if (w >= 0 && (!m_ov[k] || ordy[k])) begin
        m_ov[k] = 1; m_bits[k] = pay[k][w]; m_idx[k] = w; m_ptr[k] = (w + 1) % nreq[k];
      end else if (ordy[k]) begin
        m_ov[k] = 0;
      end
    end
  end

  // Compare every instance against the model mid-cycle.
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model_out_valid[%0d]", k), int'(d_ov[k]), int'(m_ov[k]));
      check($sformatf("model_out_bits[%0d]", k), int'(d_bits[k]), int'(m_bits[k]));
      check($sformatf("model_grant_idx[%0d]", k), d_idx[k], m_idx[k]);
      check($sformatf("model_in_ready[%0d]", k), d_rdy[k], exp_ready(k));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    vld[0]  = 4'hF;
    vld[1]  = 4'h0;
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) pay[k][i] = vrf_read_req_t'(17'(i * 17'h1111 + k));

    // Reset held 3 cycles with all requesters valid.
    for (int r = 0; r < 3; r++) begin
      cyc();
      check("rst_out_valid", int'(ov0), 0);
      check("rst_out_bits", int'(d_bits[0]), 0);
      check("rst_in_ready", int'(rdy0), 0);
    end
    reset = 1'b0;
    #1;
    check("first_ready_req0", int'(rdy0), 1);

    // Round-robin with everyone valid: 0,1,2,3,0,1 back to back.
    for (int k = 0; k < 6; k++) begin
      cyc();
      check($sformatf("rr_seq_idx%0d", k), int'(oidx0), k % 4);
      check($sformatf("rr_seq_valid%0d", k), int'(ov0), 1);
    end

    // Backpressure: grant req2 then stall 4 cycles.
    vld[0] = 4'b1100;
    pay[0][2].vs = 5'h1A;
    pay[0][2].offset = 7'h33;
    cyc();
    ordy[0] = 1'b0;
    vld[0]  = 4'b1000;
    for (int r = 0; r < 4; r++) begin
      #1;
      check("bp_idx", int'(oidx0), 2);
      check("bp_vs", int'(ovs0), 'h1A);
      check("bp_off", int'(ooff0), 'h33);
      check("bp_in_ready", int'(rdy0), 0);
      cyc();
    end
    ordy[0] = 1'b1;
    #1;
    check("bp_release_ready_req3", int'(rdy0), 4'b1000);
    cyc();
    check("bp_req3_idx", int'(oidx0), 3);
    check("bp_req3_valid", int'(ov0), 1);

    // Idle cycles must not move the pointer.
    vld[0] = 4'b0010;
    cyc();
    check("idle_req1_idx", int'(oidx0), 1);
    vld[0] = 4'b0000;
    for (int r = 0; r < 5; r++) cyc();
    check("idle_out_valid", int'(ov0), 0);
    vld[0] = 4'hF;
    #1;
    check("idle_ready_req2", int'(rdy0), 4'b0100);
    cyc();
    check("idle_req2_idx", int'(oidx0), 2);

    // Reset while a stalled request is held.
    ordy[0] = 1'b0;
    cyc();
    check("midrst_held_valid", int'(ov0), 1);
    reset = 1'b1;
    cyc();
    reset   = 1'b0;
    vld[0]  = 4'h0;
    ordy[0] = 1'b1;
    #1;
    check("midrst_out_valid", int'(ov0), 0);
    vld[0] = 4'hF;
    #1;
    check("midrst_ptr0_ready", int'(rdy0), 4'b0001);
    cyc();
    check("midrst_req0_idx", int'(oidx0), 0);
    vld[0] = 4'h0;

    // 3-way wrap with sparse requests: move ptr to 2, then only req0/req1 valid.
    vld[1] = 4'b0010;
    cyc();
    check("wrap_req1_idx", int'(oidx1), 1);
    vld[1] = 4'b0011;
    #1;
    check("wrap_ready_req0", int'(rdy1), 3'b001);
    cyc();
    check("wrap_req0_idx", int'(oidx1), 0);
    #1;
    check("wrap_ready_req1", int'(rdy1), 3'b010);
    cyc();
    check("wrap_req1b_idx", int'(oidx1), 1);
    vld[1] = 4'h0;
    cyc();

    // Randomized traffic on both instances, model-checked every cycle.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < 2; k++) begin
        vld[k]  = 4'($urandom_range(0, 15));
        ordy[k] = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++) pay[k][i] = vrf_read_req_t'(17'($urandom));
      end
      vld[1][3] = 1'b0;
      cyc();
    end
    reset = 1'b0;
    vld[0] = 4'h0;
    vld[1] = 4'h0;
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
